// File: rtl/shift_deser_rx.sv
// Framed serial receiver: start(0), DATA_W data bits, stop(1), sampled on an external bit strobe.
// Define SHIFT_DESER_PARITY_CHECK_EN to expect an even-parity bit between the data bits and the stop bit.
module shift_deser_rx #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk_amisha,
  input  logic              reset_amisha,
  input  logic              bit_en_amisha,
  input  logic              sin_amisha,
  output logic [DATA_W-1:0] q_amisha,
  output logic              valid_amisha,
  output logic              ferr_amisha,
  output logic              busy_amisha
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef SHIFT_DESER_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, STOP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_t;
`endif

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   sreg_reg, sreg_next;
  logic [DATA_W-1:0]   q_reg, q_next;
  logic                valid_reg, valid_next;
  logic                ferr_reg, ferr_next;
  logic [DATA_W-1:0]   sreg_shift;
  logic                frame_good;

  // Shift direction decides where the incoming bit lands.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_in
        assign sreg_shift[gi] = sin_amisha;
      end else begin : g_mv
        assign sreg_shift[gi] = sreg_reg[gi-1];
      end
    end else begin : g_lsb
      if (gi == DATA_W - 1) begin : g_in
        assign sreg_shift[gi] = sin_amisha;
      end else begin : g_mv
        assign sreg_shift[gi] = sreg_reg[gi+1];
      end
    end
  end

`ifdef SHIFT_DESER_PARITY_CHECK_EN
  logic par_reg, par_next;
  assign frame_good = sin_amisha & ~((^sreg_reg) ^ par_reg);
`else
  assign frame_good = sin_amisha;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sreg_next  = sreg_reg;
    q_next     = q_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
    par_next   = par_reg;
`endif
    if (bit_en_amisha) begin
      case (state_reg)
        IDLE: begin
          if (!sin_amisha) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          sreg_next = sreg_shift;
          if (cnt_reg == CNT_LAST) begin
`ifdef SHIFT_DESER_PARITY_CHECK_EN
            state_next = PAR;
`else
            state_next = STOP;
`endif
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
`ifdef SHIFT_DESER_PARITY_CHECK_EN
        PAR: begin
          par_next   = sin_amisha;
          state_next = STOP;
        end
`endif
        STOP: begin
          state_next = IDLE;
          if (frame_good) begin
            q_next     = sreg_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sreg_reg  <= '0;
      q_reg     <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sreg_reg  <= sreg_next;
      q_reg     <= q_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
      par_reg   <= par_next;
`endif
    end
  end

  assign q_amisha     = q_reg;
  assign valid_amisha = valid_reg;
  assign ferr_amisha  = ferr_reg;
  assign busy_amisha  = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_deser_rx.sv
// Bench for shift_deser_rx: LSB-first and MSB-first instances share one serial line;
// a scoreboard queue holds the expected result and arrival cycle of each frame.
module tb_shift_deser_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_en;
  logic       sin;
  logic [7:0] q_l, q_m;
  logic       valid_l, valid_m, ferr_l, ferr_m, busy_l, busy_m;

  int vectors = 0;
  int errors  = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic       err;
    logic [7:0] q_l;
    logic [7:0] q_m;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] last_l = 8'h00;
  logic [7:0] last_m = 8'h00;
`ifdef SHIFT_DESER_PARITY_CHECK_EN
  logic       par_flip = 1'b0;
`endif

  shift_deser_rx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_amisha(clk), .reset_amisha(rst_n), .bit_en_amisha(bit_en), .sin_amisha(sin),
    .q_amisha(q_l), .valid_amisha(valid_l), .ferr_amisha(ferr_l), .busy_amisha(busy_l)
  );

  shift_deser_rx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk_amisha(clk), .reset_amisha(rst_n), .bit_en_amisha(bit_en), .sin_amisha(sin),
    .q_amisha(q_m), .valid_amisha(valid_m), .ferr_amisha(ferr_m), .busy_amisha(busy_m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Every output pulse must match the oldest outstanding frame, in the expected cycle.
  always @(negedge clk) begin
    if (valid_l || ferr_l || valid_m || ferr_m) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {12'h0, valid_l, ferr_l, valid_m, ferr_m}, 16'h0);
      end else begin
        mon_e = sb.pop_front();
        $display("frame: q_l=%02h q_m=%02h valid=%0b/%0b ferr=%0b/%0b cycle=%0d", q_l, q_m,
                 valid_l, valid_m, ferr_l, ferr_m, cycle_cnt);
        check("valid_l", {15'h0, valid_l}, {15'h0, ~mon_e.err});
        check("ferr_l",  {15'h0, ferr_l},  {15'h0, mon_e.err});
        check("q_l",     {8'h0, q_l},      {8'h0, mon_e.q_l});
        check("valid_m", {15'h0, valid_m}, {15'h0, ~mon_e.err});
        check("ferr_m",  {15'h0, ferr_m},  {15'h0, mon_e.err});
        check("q_m",     {8'h0, q_m},      {8'h0, mon_e.q_m});
        check("pulse_cycle", cycle_cnt[15:0], mon_e.cyc[15:0]);
      end
    end
  end

  // One bit strobe; gap=1 leaves bit_en high for continuous operation.
  task automatic strobe(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    if (gap > 1) begin
      bit_en = 1'b0;
      repeat (gap - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // seq[i] is the i-th data bit on the wire.
  task automatic send_frame(input logic [7:0] seq, input logic stop_b, input int gap);
    exp_t       e;
    logic [7:0] rev;
    logic       good;
    for (int i = 0; i < 8; i++) rev[i] = seq[7-i];
    strobe(1'b0, gap);
    check("busy_l_start", {15'h0, busy_l}, 16'h1);
    check("busy_m_start", {15'h0, busy_m}, 16'h1);
    for (int i = 0; i < 8; i++) strobe(seq[i], gap);
`ifdef SHIFT_DESER_PARITY_CHECK_EN
    strobe((^seq) ^ par_flip, gap);
    good = stop_b & ~par_flip;
`else
    good = stop_b;
`endif
    if (good) begin
      last_l = seq;
      last_m = rev;
    end
    e.err = ~good;
    e.q_l = last_l;
    e.q_m = last_m;
    e.cyc = cycle_cnt + 1;
    sb.push_back(e);
    strobe(stop_b, gap);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check(tag, 16'(sb.size()), 16'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    sin    = 1'b1;
    #3;
    check("rst_q_l",   {8'h0, q_l}, 16'h0);
    check("rst_q_m",   {8'h0, q_m}, 16'h0);
    check("rst_outs",  {12'h0, valid_l, ferr_l, valid_m, ferr_m}, 16'h0);
    check("rst_busy",  {14'h0, busy_l, busy_m}, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 0xD3 LSB first on the wire; MSB-first instance sees 0xCB.
    send_frame(8'hD3, 1'b1, 4);
    settle_and_check("pending_f1");
    // Stream that is 0xD3 MSB first.
    send_frame(8'hCB, 1'b1, 4);
    settle_and_check("pending_f2");
    // Bad stop bit: ferr only, q holds.
    send_frame(8'hA5, 1'b0, 4);
    settle_and_check("pending_ferr");
    check("hold_q_m", {8'h0, q_m}, 16'h00D3);

    // Back-to-back with bit_en held high, then an idle line that must start nothing.
    send_frame(8'h3C, 1'b1, 1);
    send_frame(8'hC3, 1'b1, 1);
    sin = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    bit_en = 1'b0;
    check("pending_b2b", 16'(sb.size()), 16'h0);
    check("idle_busy", {14'h0, busy_l, busy_m}, 16'h0);

    // Abort mid-frame with an asynchronous reset.
    strobe(1'b0, 4);
    for (int i = 0; i < 4; i++) strobe(1'b1, 4);
    check("busy_mid", {14'h0, busy_l, busy_m}, 16'h3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_q_l",  {8'h0, q_l}, 16'h0);
    check("abort_q_m",  {8'h0, q_m}, 16'h0);
    check("abort_outs", {12'h0, valid_l, ferr_l, valid_m, ferr_m}, 16'h0);
    check("abort_busy", {14'h0, busy_l, busy_m}, 16'h0);
    last_l = 8'h00;
    last_m = 8'h00;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h81, 1'b1, 4);
    settle_and_check("pending_81");

`ifdef SHIFT_DESER_PARITY_CHECK_EN
    par_flip = 1'b0;
    send_frame(8'hD3, 1'b1, 4);
    settle_and_check("pending_par_ok");
    par_flip = 1'b1;
    send_frame(8'hD3, 1'b1, 4);
    settle_and_check("pending_par_bad");
    check("par_hold_q_l", {8'h0, q_l}, 16'h00D3);
    par_flip = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
